// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline types for the register scoreboard: write descriptor,
// register address and producer kinds, plus the counter sizing constants.
package reg_scoreboard_pkg;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [1:0] {
    SRC_NOP = 2'd0,
    SRC_ALU = 2'd1,
    SRC_MEM = 2'd2
  } wr_src_e;

  typedef struct packed {
    logic       valid;
    wr_src_e    src;
    creg_addr_t dst;
    logic [31:0] value;
  } write_reg_t;

  localparam int unsigned SB_CNT_W   = 2;
  localparam int unsigned SB_CNT_MAX = (1 << SB_CNT_W) - 1;

endpackage

// File: rtl/reg_scoreboard_sb_reg_cell.sv
// One scoreboard entry: outstanding-write counter and the producer kind of
// the youngest accepted writer for a single GPR.
module sb_reg_cell
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  wr_src_e          kind_i,
  output logic [CNT_W-1:0] cnt_o,
  output wr_src_e          kind_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  wr_src_e          kind_q, kind_d;

  always_comb begin
    cnt_d  = cnt_q;
    kind_d = kind_q;
    if (clr_i) begin
      cnt_d  = '0;
      kind_d = SRC_NOP;
    end else begin
      // Simultaneous inc and dec cancel; the kind still follows the new writer.
      if (inc_i && !dec_i) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (inc_i) begin
        kind_d = kind_i;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      kind_q <= SRC_NOP;
    end else begin
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign kind_o = kind_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard between decode and issue: tracks outstanding GPR
// writes, gates issue on non-forwardable producers, retires on writeback.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  creg_addr_t issue_rs,
  input  logic       issue_rs_used,
  input  creg_addr_t issue_rt,
  input  logic       issue_rt_used,
  input  write_reg_t issue_wr,
  output logic       fwd_rs,
  output logic       fwd_rt,
  input  logic       wb_valid,
  input  creg_addr_t wb_dst,
  input  logic       flush,
  output logic       busy,
  output logic       err_underflow
);

  logic [CNT_W-1:0] cnt_all  [32];
  wr_src_e          kind_all [32];
  logic [31:1]      inc, dec;
  logic             rs_pend, rt_pend, hazard_rs, hazard_rt, dst_full;
  logic             accept, wr_ok, rel_ok;
  logic             err_q, err_d;
  logic             unused_value;

  assign unused_value = ^issue_wr.value;

  // r0 is never tracked: a constant empty entry keeps lookups uniform.
  assign cnt_all[0]  = '0;
  assign kind_all[0] = SRC_NOP;

  for (genvar r = 1; r < 32; r++) begin : g_cell
    sb_reg_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (flush),
      .inc_i  (inc[r]),
      .dec_i  (dec[r]),
      .kind_i (issue_wr.src),
      .cnt_o  (cnt_all[r]),
      .kind_o (kind_all[r])
    );
  end

  always_comb begin
    rs_pend   = issue_rs_used && (issue_rs != '0) && (cnt_all[issue_rs] != '0);
    rt_pend   = issue_rt_used && (issue_rt != '0) && (cnt_all[issue_rt] != '0);
    hazard_rs = rs_pend && (kind_all[issue_rs] != SRC_ALU);
    hazard_rt = rt_pend && (kind_all[issue_rt] != SRC_ALU);
    fwd_rs    = rs_pend && (kind_all[issue_rs] == SRC_ALU);
    fwd_rt    = rt_pend && (kind_all[issue_rt] == SRC_ALU);
    dst_full  = issue_wr.valid && (issue_wr.dst != '0) && (cnt_all[issue_wr.dst] == '1);

    issue_ready = !flush && !hazard_rs && !hazard_rt && !dst_full;
    accept      = issue_valid && issue_ready;
    wr_ok       = accept && issue_wr.valid && (issue_wr.dst != '0);
    rel_ok      = !flush && wb_valid && (wb_dst != '0);
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      inc[r] = wr_ok && (issue_wr.dst == r[4:0]);
      dec[r] = rel_ok && (wb_dst == r[4:0]) && (cnt_all[r] != '0);
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned r = 1; r < 32; r++) begin
      busy = busy | (cnt_all[r] != '0);
    end
  end

  assign err_d = err_q | (rel_ok && (cnt_all[wb_dst] == '0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: each scenario task drives vectors and
// compares outputs against hand-derived values.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       issue_valid, issue_ready;
  creg_addr_t issue_rs, issue_rt;
  logic       issue_rs_used, issue_rt_used;
  write_reg_t issue_wr;
  logic       fwd_rs, fwd_rt;
  logic       wb_valid;
  creg_addr_t wb_dst;
  logic       flush, busy, err_underflow;

  int tests_run    = 0;
  int tests_failed = 0;

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs      (issue_rs),
    .issue_rs_used (issue_rs_used),
    .issue_rt      (issue_rt),
    .issue_rt_used (issue_rt_used),
    .issue_wr      (issue_wr),
    .fwd_rs        (fwd_rs),
    .fwd_rt        (fwd_rt),
    .wb_valid      (wb_valid),
    .wb_dst        (wb_dst),
    .flush         (flush),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rs_used = 0; issue_rt = 0; issue_rt_used = 0;
    issue_wr = '0; wb_valid = 0; wb_dst = 0; flush = 0;
  endtask

  task automatic set_wr(input logic v, input wr_src_e s, input int d);
    issue_wr.valid = v; issue_wr.src = s; issue_wr.dst = creg_addr_t'(d);
    issue_wr.value = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    #3;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", issue_ready); end
    tests_run++; if ({fwd_rs, fwd_rt} !== 2'b00) begin tests_failed++; $display("FAIL reset_fwd got %b want 00", {fwd_rs, fwd_rt}); end
    tests_run++; if (err_underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err_underflow); end
    tick();
    resetn = 1;
    tick();
  endtask

  task automatic test_alu_fwd();
    idle(); issue_valid = 1; set_wr(1, SRC_ALU, 5); #1;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL alu_issue_ready got %b want 1", issue_ready); end
    tick();
    idle(); issue_valid = 1; issue_rs = 5; issue_rs_used = 1; issue_rt = 5; issue_rt_used = 0; #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL alu_busy got %b want 1", busy); end
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL alu_read_ready got %b want 1", issue_ready); end
    tests_run++; if (fwd_rs !== 1'b1) begin tests_failed++; $display("FAIL alu_fwd_rs got %b want 1", fwd_rs); end
    tests_run++; if (fwd_rt !== 1'b0) begin tests_failed++; $display("FAIL alu_fwd_rt_unused got %b want 0", fwd_rt); end
    tick();
    idle(); wb_valid = 1; wb_dst = 5; tick();
    idle(); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL alu_release_busy got %b want 0", busy); end
  endtask

  task automatic test_load_hazard();
    idle(); issue_valid = 1; set_wr(1, SRC_MEM, 8); tick();
    idle(); issue_valid = 1; issue_rt = 8; issue_rt_used = 1; #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL lw_stall got %b want 0", issue_ready); end
    tests_run++; if (fwd_rt !== 1'b0) begin tests_failed++; $display("FAIL lw_no_fwd got %b want 0", fwd_rt); end
    tick();
    wb_valid = 1; wb_dst = 8; #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL lw_wb_same_cycle got %b want 0", issue_ready); end
    tick();
    wb_valid = 0; #1;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL lw_after_wb got %b want 1", issue_ready); end
    tests_run++; if (fwd_rt !== 1'b0) begin tests_failed++; $display("FAIL lw_after_wb_fwd got %b want 0", fwd_rt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL lw_after_wb_busy got %b want 0", busy); end
    tick();
  endtask

  task automatic test_saturation();
    idle(); issue_valid = 1; set_wr(1, SRC_ALU, 3);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL sat_accept%0d got %b want 1", i, issue_ready); end
      tick();
    end
    #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL sat_full got %b want 0", issue_ready); end
    tick();
    wb_valid = 1; wb_dst = 3; #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL sat_full_wb_cycle got %b want 0", issue_ready); end
    tick();
    wb_valid = 0; #1;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL sat_after_wb got %b want 1", issue_ready); end
    tick();
    idle(); wb_valid = 1; wb_dst = 3;
    tick(); tick(); #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL sat_drain_busy got %b want 1", busy); end
    tick();
    idle(); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL sat_drained got %b want 0", busy); end
    tests_run++; if (err_underflow !== 1'b0) begin tests_failed++; $display("FAIL sat_no_underflow got %b want 0", err_underflow); end
  endtask

  task automatic test_back_to_back();
    idle(); issue_valid = 1; set_wr(1, SRC_MEM, 4); tick();
    set_wr(1, SRC_ALU, 4); wb_valid = 1; wb_dst = 4; #1;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready got %b want 1", issue_ready); end
    tick();
    idle(); issue_valid = 1; issue_rs = 4; issue_rs_used = 1; #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_cnt_kept got %b want 1", busy); end
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_kind_alu_ready got %b want 1", issue_ready); end
    tests_run++; if (fwd_rs !== 1'b1) begin tests_failed++; $display("FAIL b2b_kind_alu_fwd got %b want 1", fwd_rs); end
    tick();
    idle(); wb_valid = 1; wb_dst = 4; tick();
    idle(); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_single_release got %b want 0", busy); end
  endtask

  task automatic test_flush();
    idle(); issue_valid = 1; set_wr(1, SRC_MEM, 9); tick();
    set_wr(1, SRC_ALU, 10); tick();
    set_wr(1, SRC_ALU, 11); wb_valid = 1; wb_dst = 10; flush = 1; #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready got %b want 0", issue_ready); end
    tick();
    idle(); issue_valid = 1; issue_rs = 9; issue_rs_used = 1; issue_rt = 10; issue_rt_used = 1; #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got %b want 0", busy); end
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_read9 got %b want 1", issue_ready); end
    tests_run++; if ({fwd_rs, fwd_rt} !== 2'b00) begin tests_failed++; $display("FAIL flush_fwd got %b want 00", {fwd_rs, fwd_rt}); end
    tests_run++; if (err_underflow !== 1'b0) begin tests_failed++; $display("FAIL flush_wb_ignored got %b want 0", err_underflow); end
    tick();
  endtask

  task automatic test_underflow();
    idle(); wb_valid = 1; wb_dst = 12; tick();
    idle(); #1;
    tests_run++; if (err_underflow !== 1'b1) begin tests_failed++; $display("FAIL uf_set got %b want 1", err_underflow); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL uf_busy got %b want 0", busy); end
    flush = 1; tick();
    flush = 0; #1;
    tests_run++; if (err_underflow !== 1'b1) begin tests_failed++; $display("FAIL uf_sticky_flush got %b want 1", err_underflow); end
    resetn = 0; #1;
    tests_run++; if (err_underflow !== 1'b0) begin tests_failed++; $display("FAIL uf_reset_clear got %b want 0", err_underflow); end
    tick();
    resetn = 1; tick();
  endtask

  task automatic test_async_reset();
    idle(); issue_valid = 1; set_wr(1, SRC_MEM, 7); tick();
    idle(); #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ar_busy_before got %b want 1", busy); end
    #1 resetn = 0; #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ar_busy_immediate got %b want 0", busy); end
    tick();
    resetn = 1; issue_valid = 1; issue_rs = 7; issue_rs_used = 1; #1;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL ar_read7 got %b want 1", issue_ready); end
    tick();
  endtask

  task automatic test_r0();
    idle(); issue_valid = 1; set_wr(1, SRC_MEM, 0);
    issue_rs = 0; issue_rs_used = 1; issue_rt = 0; issue_rt_used = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL r0_ready%0d got %b want 1", i, issue_ready); end
      tests_run++; if ({fwd_rs, fwd_rt} !== 2'b00) begin tests_failed++; $display("FAIL r0_fwd%0d got %b want 00", i, {fwd_rs, fwd_rt}); end
      tick();
    end
    wb_valid = 1; wb_dst = 0; tick();
    idle(); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL r0_busy got %b want 0", busy); end
    tests_run++; if (err_underflow !== 1'b0) begin tests_failed++; $display("FAIL r0_wb_no_err got %b want 0", err_underflow); end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_hazard();
    test_saturation();
    test_back_to_back();
    test_flush();
    test_underflow();
    test_async_reset();
    test_r0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
